// File: rtl/nco_phase_gen_pkg.sv
// Shared audio-path constants and types for the NCO front end.
// Sample and LUT widths are fixed by the sine table contract.
package nco_phase_gen_pkg;

  localparam int SAMPLE_W     = 14;
  localparam int LUT_ADDR_W   = 8;
  localparam int PHASE_W_DEF  = 24;
  localparam int TICK_DIV_DEF = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nco_state_e;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/nco_phase_gen_if.sv
// Sample stream from the NCO to its downstream consumer.
// Plain valid/ready; data is a raw 14-bit two's-complement word.
interface nco_phase_gen_if;
  import nco_phase_gen_pkg::*;

  sample_t sample;
  logic    sample_valid;
  logic    sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/nco_phase_gen_tick.sv
// Sample-rate divider: counts 0..TICK_DIV-1 while running.
// Held at zero when idle or cleared; tick marks the last count.
module nco_tick_gen #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/nco_phase_gen.sv
// NCO front end: phase accumulator, LUT address, sample register
// and valid/ready output with sticky overrun reporting.
module nco_phase_gen
  import nco_phase_gen_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  phase_clr,
  input  logic [PHASE_W-1:0]    fcw,
  input  logic                  fcw_load,
  output logic [LUT_ADDR_W-1:0] lut_addr,
  input  sample_t               lut_data,
  nco_phase_gen_if.master       sif,
  output logic                  overrun
);

  nco_state_e state;
  nco_state_e state_nxt;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fcw_shadow;
  logic [PHASE_W-1:0] fcw_active;
  sample_t            sample_q;
  logic               valid_q;
  logic               overrun_q;

  logic run;
  logic cnt_clr;
  logic tick;
  logic tick_eff;
  logic xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN:  if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign run = (state == RUN);
  // Leaving RUN zeroes the counter so IDLE always sees it at 0.
  assign cnt_clr = phase_clr || (run && !enable);

  nco_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (cnt_clr),
    .tick (tick)
  );

  assign tick_eff = tick && !phase_clr;
  assign xfer = valid_q && sif.sample_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcw_shadow <= '0;
    end else if (fcw_load) begin
      fcw_shadow <= fcw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      fcw_active <= '0;
      overrun_q  <= 1'b0;
    end else if (phase_clr) begin
      acc        <= '0;
      fcw_active <= fcw_shadow;
      overrun_q  <= 1'b0;
    end else if (tick) begin
      acc        <= acc + fcw_active;
      fcw_active <= fcw_shadow;
      if (valid_q && !sif.sample_ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Sample is taken from the pre-increment address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (tick_eff) begin
      sample_q <= lut_data;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      valid_q  <= 1'b0;
    end
  end

  assign lut_addr         = acc[PHASE_W-1 -: LUT_ADDR_W];
  assign sif.sample       = sample_q;
  assign sif.sample_valid = valid_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen with a queue-based sample scoreboard.
// TICK_DIV is shortened to 4 so every tick lands on a hand-counted edge.
module tb_nco_phase_gen;
  import nco_phase_gen_pkg::*;

  localparam int PW = 24;
  localparam int TD = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          phase_clr;
  logic [PW-1:0] fcw;
  logic          fcw_load;
  logic [7:0]    lut_addr;
  sample_t       lut_data;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  sample_t exp_q[$];

  nco_phase_gen_if sif ();

  nco_phase_gen #(
    .PHASE_W (PW),
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .phase_clr(phase_clr),
    .fcw      (fcw),
    .fcw_load (fcw_load),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .sif      (sif),
    .overrun  (overrun)
  );

  function automatic sample_t lut(input logic [7:0] a);
    case (a)
      8'd0:    lut = 14'h0000;
      8'd1:    lut = 14'h0019;
      8'd2:    lut = 14'h0032;
      8'd3:    lut = 14'h004B;
      8'd4:    lut = 14'h0064;
      8'd64:   lut = 14'h0400;
      8'd128:  lut = 14'h0000;
      8'd192:  lut = 14'h3C00;
      default: lut = {6'h15, a};
    endcase
  endfunction

  assign lut_data = lut(lut_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_fcw(input logic [PW-1:0] v);
    fcw = v;
    fcw_load = 1'b1;
    step(1);
    fcw_load = 1'b0;
  endtask

  task automatic clr_pulse();
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
  endtask

  initial begin
    int vcnt;
    rst_n = 1'b0;
    enable = 1'b0;
    phase_clr = 1'b0;
    fcw = '0;
    fcw_load = 1'b0;
    sif.sample_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && sif.sample_valid && sif.sample_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sample_unexpected: got %h expected none",
                     sif.sample);
          end else begin
            sample_t e;
            e = exp_q.pop_front();
            if (sif.sample !== e) begin
              errors++;
              $display("FAIL sample: got %h expected %h",
                       sif.sample, e);
            end
          end
        end
      end
    join_none

    step(3);
    chk("rst_addr", 32'(lut_addr), 32'h0);
    chk("rst_sample", 32'(sif.sample), 32'h0);
    chk("rst_valid", 32'(sif.sample_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    step(1);

    // step 1: addresses 0,1,2,3
    load_fcw(24'h010000);
    clr_pulse();
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h0019);
    exp_q.push_back(14'h0032);
    exp_q.push_back(14'h004B);
    enable = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 18; i++) begin
      step(1);
      if (sif.sample_valid) vcnt++;
    end
    chk("t1_valid_cycles", 32'(vcnt), 32'd4);
    chk("t1_addr", 32'(lut_addr), 32'd4);
    enable = 1'b0;
    step(2);

    // quarter-turn step, wraps on the fifth sample
    load_fcw(24'h400000);
    clr_pulse();
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h0400);
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h3C00);
    exp_q.push_back(14'h0000);
    enable = 1'b1;
    step(22);
    chk("t2_addr", 32'(lut_addr), 32'd64);
    chk("t2_valid", 32'(sif.sample_valid), 32'h0);
    enable = 1'b0;
    step(2);

    // overrun with ready low across two ticks
    clr_pulse();
    sif.sample_ready = 1'b0;
    enable = 1'b1;
    step(10);
    chk("t3_valid_held", 32'(sif.sample_valid), 32'h1);
    chk("t3_sample_2nd", 32'(sif.sample), 32'h0400);
    chk("t3_overrun", 32'(overrun), 32'h1);
    chk("t3_addr", 32'(lut_addr), 32'd128);
    exp_q.push_back(14'h0400);
    sif.sample_ready = 1'b1;
    step(1);
    chk("t3_valid_clr", 32'(sif.sample_valid), 32'h0);
    chk("t3_overrun_sticky", 32'(overrun), 32'h1);
    phase_clr = 1'b1;
    sif.sample_ready = 1'b0;
    step(1);
    phase_clr = 1'b0;
    chk("t3_overrun_cleared", 32'(overrun), 32'h0);
    step(7);
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h0400);
    sif.sample_ready = 1'b1;
    step(1);
    chk("t3_tick_xfer_valid", 32'(sif.sample_valid), 32'h1);
    chk("t3_tick_xfer_sample", 32'(sif.sample), 32'h0400);
    chk("t3_tick_xfer_ovr", 32'(overrun), 32'h0);
    step(1);
    chk("t3_final_ovr", 32'(overrun), 32'h0);
    enable = 1'b0;
    step(2);

    // fcw update mid-period
    load_fcw(24'h010000);
    clr_pulse();
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h0019);
    exp_q.push_back(14'h0032);
    exp_q.push_back(14'h0064);
    enable = 1'b1;
    step(6);
    load_fcw(24'h020000);
    step(3);
    chk("t4_addr_a", 32'(lut_addr), 32'd2);
    step(4);
    chk("t4_addr_b", 32'(lut_addr), 32'd4);
    step(4);
    chk("t4_addr_c", 32'(lut_addr), 32'd6);

    // asynchronous reset mid-period
    step(1);
    chk("t5_pre_sample", 32'(sif.sample), 32'h0064);
    rst_n = 1'b0;
    #1;
    chk("t5_addr", 32'(lut_addr), 32'h0);
    chk("t5_sample", 32'(sif.sample), 32'h0);
    chk("t5_valid", 32'(sif.sample_valid), 32'h0);
    chk("t5_overrun", 32'(overrun), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("t5_no_early", 32'(sif.sample_valid), 32'h0);
    exp_q.push_back(14'h0000);
    step(1);
    chk("t5_first_valid", 32'(sif.sample_valid), 32'h1);
    enable = 1'b0;
    step(2);

    // phase_clr on the tick cycle
    load_fcw(24'h010000);
    clr_pulse();
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h0019);
    enable = 1'b1;
    step(12);
    chk("t6_addr_pre", 32'(lut_addr), 32'd2);
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
    chk("t6_addr_clr", 32'(lut_addr), 32'h0);
    chk("t6_tick_supp", 32'(sif.sample_valid), 32'h0);
    exp_q.push_back(14'h0000);
    step(3);
    chk("t6_no_early", 32'(sif.sample_valid), 32'h0);
    step(1);
    chk("t6_valid", 32'(sif.sample_valid), 32'h1);
    chk("t6_addr_next", 32'(lut_addr), 32'd1);
    step(2);
    enable = 1'b0;
    step(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
